// File: rtl/regm_pkg.sv
// Shared definitions for the regm register store and its host-side bridge:
// default widths, the {id,data} store-word packing and the host FSM states.
package regm_pkg;

    localparam int REGM_ID_W   = 8;
    localparam int REGM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2
    } host_state_e;

    // Both ends of the store link must agree on this layout: id in the upper bits.
    function automatic logic [REGM_ID_W+REGM_DATA_W-1:0] pack_store(
        input logic [REGM_ID_W-1:0]   id,
        input logic [REGM_DATA_W-1:0] data
    );
        return {id, data};
    endfunction

endpackage

// File: rtl/regm_host.sv
// Initiator-side bridge to regm: turns valid/ready write/read commands into
// single-cycle store/request strobes and returns read results (with timeout).
module regm_host
    import regm_pkg::*;
#(
    parameter int ID_W    = REGM_ID_W,
    parameter int DATA_W  = REGM_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [ID_W-1:0]        cmd_id,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   store_data_f,
    output logic [ID_W+DATA_W-1:0] store_data,
    output logic                   req_id_f,
    output logic [ID_W-1:0]        req_id,
    input  logic [DATA_W-1:0]      req_data,
    input  logic                   req_data_f
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    host_state_e state, next_state;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic [ID_W-1:0]  rd_id, rd_id_d;

    logic                   cmd_ready_d;
    logic                   rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_d;
    logic [DATA_W-1:0]      rsp_rdata_d;
    logic                   rsp_err_d;
    logic                   store_data_f_d;
    logic [ID_W+DATA_W-1:0] store_data_d;
    logic                   req_id_f_d;
    logic [ID_W-1:0]        req_id_d;

    logic wr_fire, rd_fire, rd_done;

    // cmd_ready is registered, so it also gates acceptance in the first IDLE cycle after reset.
    assign wr_fire = (state == ST_IDLE) && cmd_valid && cmd_ready && cmd_wr;
    assign rd_fire = (state == ST_IDLE) && cmd_valid && cmd_ready && !cmd_wr;
    assign rd_done = (state == ST_RD_WAIT) && (req_data_f || (cnt == CNT_LAST));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            ST_IDLE:    if (rd_fire)   next_state = ST_RD_WAIT;
            ST_RD_WAIT: if (rd_done)   next_state = ST_RSP;
            ST_RSP:     if (rsp_ready) next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d    = (next_state == ST_IDLE);
        rsp_valid_d    = (next_state == ST_RSP);
        rsp_id_d       = rsp_id;
        rsp_rdata_d    = rsp_rdata;
        rsp_err_d      = rsp_err;
        store_data_f_d = wr_fire;
        store_data_d   = '0;
        req_id_f_d     = rd_fire;
        req_id_d       = '0;
        rd_id_d        = rd_id;
        cnt_d          = '0;

        if (wr_fire) begin
            store_data_d = (ID_W+DATA_W)'(pack_store(REGM_ID_W'(cmd_id), REGM_DATA_W'(cmd_wdata)));
        end
        if (rd_fire) begin
            req_id_d = cmd_id;
            rd_id_d  = cmd_id;
        end
        if (state == ST_RD_WAIT) begin
            cnt_d = cnt + CNT_W'(1);
        end
        // Data arriving on the last wait cycle still wins over the timeout.
        if (rd_done) begin
            rsp_id_d    = rd_id;
            rsp_rdata_d = req_data_f ? req_data : '0;
            rsp_err_d   = !req_data_f;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cnt          <= '0;
            rd_id        <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            store_data_f <= 1'b0;
            store_data   <= '0;
            req_id_f     <= 1'b0;
            req_id       <= '0;
        end else begin
            cnt          <= cnt_d;
            rd_id        <= rd_id_d;
            cmd_ready    <= cmd_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_id       <= rsp_id_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            store_data_f <= store_data_f_d;
            store_data   <= store_data_d;
            req_id_f     <= req_id_f_d;
            req_id       <= req_id_d;
        end
    end

endmodule

// File: tb/tb_regm_host.sv
// Directed bench for regm_host: writes, reads against a small regm model with
// programmable latency, timeout, response backpressure and reset mid-read.
module tb_regm_host;

    localparam int ID_W    = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int HIST    = 17;

    logic                   sys_clk = 1'b0;
    logic                   sys_rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_wr;
    logic [ID_W-1:0]        cmd_id;
    logic [DATA_W-1:0]      cmd_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   store_data_f;
    logic [ID_W+DATA_W-1:0] store_data;
    logic                   req_id_f;
    logic [ID_W-1:0]        req_id;
    logic [DATA_W-1:0]      req_data;
    logic                   req_data_f;

    int n_err = 0;
    int n_chk = 0;

    always #5 sys_clk = ~sys_clk;

    regm_host #(.ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_wr       (cmd_wr),
        .cmd_id       (cmd_id),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .store_data_f (store_data_f),
        .store_data   (store_data),
        .req_id_f     (req_id_f),
        .req_id       (req_id),
        .req_data     (req_data),
        .req_data_f   (req_data_f)
    );

    // regm model: stores on the strobe, replies resp_lat cycles after req_id_f.
    logic [DATA_W-1:0] mem [256];
    logic              f_hist  [HIST];
    logic [ID_W-1:0]   id_hist [HIST];
    int                resp_lat;
    logic              resp_en;
    logic              stray_f;
    logic              sel_f;
    logic [ID_W-1:0]   sel_id;

    always @(posedge sys_clk) begin
        if (store_data_f) mem[store_data[39:32]] <= store_data[31:0];
        f_hist[1]  <= req_id_f;
        id_hist[1] <= req_id;
        for (int i = 2; i < HIST; i++) begin
            f_hist[i]  <= f_hist[i-1];
            id_hist[i] <= id_hist[i-1];
        end
    end

    always_comb begin
        sel_f  = (resp_lat == 0) ? req_id_f : f_hist[resp_lat];
        sel_id = (resp_lat == 0) ? req_id   : id_hist[resp_lat];
        req_data_f = (resp_en && sel_f) || stray_f;
        req_data   = stray_f ? 32'hdead_beef : ((resp_en && sel_f) ? mem[sel_id] : '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    logic [DATA_W-1:0] wr_data [3];
    logic              seen_rsp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < HIST; i++) begin
            f_hist[i]  = 1'b0;
            id_hist[i] = '0;
        end
        wr_data[0] = 32'hffff_1111;
        wr_data[1] = 32'h2222_0002;
        wr_data[2] = 32'h3333_0003;
        sys_rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_id = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; resp_lat = 0; resp_en = 1'b0; stray_f = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_store_f",   64'(store_data_f), 64'd0);
        check("rst_store",     64'(store_data),   64'd0);
        check("rst_req_f",     64'(req_id_f),  64'd0);
        check("rst_req_id",    64'(req_id),    64'd0);
        sys_rst = 1'b1;
        tick();
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // Single write
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_id = 8'h01; cmd_wdata = 32'hffff_1111;
        check("wr_pre_store", 64'(store_data), 64'd0);
        tick();
        cmd_valid = 1'b0;
        check("wr_store_f", 64'(store_data_f), 64'd1);
        check("wr_store",   64'(store_data),   64'h01_ffff_1111);
        tick();
        check("wr_post_f",     64'(store_data_f), 64'd0);
        check("wr_post_store", 64'(store_data),   64'd0);

        // Three back-to-back writes
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_id = 8'(i + 1); cmd_wdata = wr_data[i];
            check("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
            tick();
            check("b2b_store_f", 64'(store_data_f), 64'd1);
            check("b2b_store",   64'(store_data),   {24'd0, 8'(i + 1), wr_data[i]});
            check("b2b_no_rsp",  64'(rsp_valid),    64'd0);
        end
        cmd_valid = 1'b0;
        tick();
        check("b2b_done_f", 64'(store_data_f), 64'd0);

        // Read id 1, responder latency 2
        resp_en = 1'b1; resp_lat = 2;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h01;
        tick();
        cmd_valid = 1'b0;
        check("rd_req_f",     64'(req_id_f),  64'd1);
        check("rd_req_id",    64'(req_id),    64'h01);
        check("rd_cmd_ready", 64'(cmd_ready), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("rd_rsp_valid_t", 64'(rsp_valid), 64'(i == 3));
        end
        check("rd_rdata",  64'(rsp_rdata), 64'hffff_1111);
        check("rd_err",    64'(rsp_err),   64'd0);
        check("rd_rsp_id", 64'(rsp_id),    64'h01);
        rsp_ready = 1'b1;
        tick();
        check("rd_hs_valid", 64'(rsp_valid), 64'd0);
        check("rd_hs_ready", 64'(cmd_ready), 64'd1);

        // Timeout on id 7, then a stray reply
        resp_en = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h07;
        tick();
        cmd_valid = 1'b0;
        check("to_req_f",  64'(req_id_f), 64'd1);
        check("to_req_id", 64'(req_id),   64'h07);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            check("to_rsp_valid_t", 64'(rsp_valid), 64'(i == TIMEOUT));
        end
        check("to_err",    64'(rsp_err),   64'd1);
        check("to_rdata",  64'(rsp_rdata), 64'd0);
        check("to_rsp_id", 64'(rsp_id),    64'h07);
        stray_f = 1'b1;
        tick();
        check("stray_valid0", 64'(rsp_valid), 64'd0);
        tick();
        stray_f = 1'b0;
        check("stray_valid1", 64'(rsp_valid), 64'd0);
        check("stray_ready",  64'(cmd_ready), 64'd1);
        check("stray_rdata",  64'(rsp_rdata), 64'd0);

        // Data on the last wait cycle beats the timeout
        resp_en = 1'b1; resp_lat = TIMEOUT - 1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h01;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            check("last_valid_t", 64'(rsp_valid), 64'(i == TIMEOUT));
        end
        check("last_err",   64'(rsp_err),   64'd0);
        check("last_rdata", 64'(rsp_rdata), 64'hffff_1111);
        tick();

        // Backpressure with zero-latency responder
        rsp_ready = 1'b0; resp_lat = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h02;
        tick();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_id = 8'h09; cmd_wdata = 32'h0909_0909;
        check("bp_req_f", 64'(req_id_f), 64'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rsp_valid),    64'd1);
            check("bp_rdata", 64'(rsp_rdata),    64'h2222_0002);
            check("bp_id",    64'(rsp_id),       64'h02);
            check("bp_err",   64'(rsp_err),      64'd0);
            check("bp_ready", 64'(cmd_ready),    64'd0);
            check("bp_nowr",  64'(store_data_f), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_hs_valid", 64'(rsp_valid),    64'd0);
        check("bp_hs_ready", 64'(cmd_ready),    64'd1);
        check("bp_hs_nowr",  64'(store_data_f), 64'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_f",     64'(store_data_f), 64'd1);
        check("bp_next_store", 64'(store_data),   64'h09_0909_0909);

        // Reset in the middle of a read
        resp_en = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h03;
        tick();
        cmd_valid = 1'b0;
        check("ab_req_f", 64'(req_id_f), 64'd1);
        tick(); tick(); tick();
        sys_rst = 1'b0;
        tick();
        sys_rst = 1'b1;
        check("ab_cmd_ready", 64'(cmd_ready),  64'd0);
        check("ab_rsp_valid", 64'(rsp_valid),  64'd0);
        check("ab_rsp_id",    64'(rsp_id),     64'd0);
        check("ab_rsp_rdata", 64'(rsp_rdata),  64'd0);
        check("ab_rsp_err",   64'(rsp_err),    64'd0);
        check("ab_store",     64'(store_data), 64'd0);
        check("ab_req_id",    64'(req_id),     64'd0);
        tick();
        check("ab_rel_ready", 64'(cmd_ready), 64'd1);
        seen_rsp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("ab_no_rsp", 64'(seen_rsp), 64'd0);

        // Read after abort, latency 1
        resp_en = 1'b1; resp_lat = 1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_id = 8'h03;
        tick();
        cmd_valid = 1'b0;
        check("post_req_id", 64'(req_id), 64'h03);
        tick();
        check("post_valid0", 64'(rsp_valid), 64'd0);
        tick();
        check("post_valid1", 64'(rsp_valid), 64'd1);
        check("post_rdata",  64'(rsp_rdata), 64'h3333_0003);
        check("post_err",    64'(rsp_err),   64'd0);
        check("post_id",     64'(rsp_id),    64'h03);
        tick();
        check("post_idle", 64'(cmd_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regm_host.md
# regm_host

Initiator-side bridge for the `regm` register store. It accepts write and read commands on a valid/ready command port and converts them into single-cycle `store_data_f` and `req_id_f` pulses. It collects the `req_data`/`req_data_f` reply, with a timeout, and returns read results on a valid/ready response port. It sits between a control source (UART/command decoder) and `regm`.

## Interface
- `ID_W`, 8: register id width
- `DATA_W`, 32: register data width
- `TIMEOUT`, 16: read-wait cycles before error response (≥2)

- `sys_clk`  in  1  system clock
- `sys_rst`  in  1  reset; one clock, reset is synchronous and active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_wr`  in  1  1 = write, 0 = read
- `cmd_id`  in  ID_W  target register id
- `cmd_wdata`  in  DATA_W  write data (ignored for reads)
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`
- `rsp_id`  out  ID_W  id of the completed read
- `rsp_rdata`  out  DATA_W  read data (0 on error)
- `rsp_err`  out  1  1 = read timed out
- `store_data_f`  out  1  one-cycle store strobe to `regm`
- `store_data`  out  ID_W+DATA_W  `{id, data}`; zero when the strobe is low
- `req_id_f`  out  1  one-cycle read-request strobe to `regm`
- `req_id`  out  ID_W  read id; zero when the strobe is low
- `req_data`  in  DATA_W  read data from `regm`
- `req_data_f`  in  1  read data valid from `regm`

## Operation
- FSM states:
  - IDLE: `cmd_ready=1`.
  - RD_WAIT: `cmd_ready=0`.
  - RSP: `cmd_ready=0`, `rsp_valid=1`.
- Write accept in IDLE: the next cycle drives `store_data_f=1` and `store_data={cmd_id,cmd_wdata}` for exactly one cycle. The FSM stays in IDLE, so back-to-back writes run at one per cycle. Writes produce no response.
- Read accept in IDLE: the next cycle drives `req_id_f=1` and `req_id=cmd_id` for one cycle. The id is latched and the FSM goes to RD_WAIT with the wait counter at 0.
- RD_WAIT:
  - Sample `req_data_f` every cycle, including the cycle `req_id_f` is high, so a zero-latency responder is supported.
  - On `req_data_f=1`: capture `req_data` into `rsp_rdata`, set `rsp_err=0`, go to RSP.
  - Otherwise the counter increments. When it reaches `TIMEOUT-1` with no `req_data_f`, set `rsp_rdata=0`, `rsp_err=1` and go to RSP.
- RSP: response outputs are held stable until `rsp_ready=1`, then the FSM returns to IDLE. A new command is accepted no earlier than the following cycle.
- `req_data_f` is ignored in IDLE and RSP (stray replies are dropped).
- Reset (sampled `sys_rst=0` at a clock edge) aborts any operation, including mid-read and a pending response. No response is emitted for an aborted read.
- Reset values (all outputs registered):
  - `cmd_ready=0` during reset, 1 on the first cycle after release.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `store_data_f=0`, `store_data=0`, `req_id_f=0`, `req_id=0`.
  - FSM in IDLE, counter 0.

## Timing
- Write: command accepted at edge k; `store_data_f` high in cycle k..k+1.
- Read, responder latency L (`req_data_f` L cycles after `req_id_f`, L ≥ 0):
  - `req_id_f` high in the cycle after acceptance.
  - `rsp_valid` rises 1 cycle after `req_data_f`, i.e. L+1 cycles after `req_id_f`.
- Timeout: `rsp_valid` with `rsp_err=1` rises TIMEOUT cycles after `req_id_f` rises.
- `req_data_f` on exactly the last wait cycle wins over timeout (data, `rsp_err=0`).
- Throughput: one read per L+3 cycles minimum with `rsp_ready` tied high.

## Structure
- Shared package `regm_pkg` holds:
  - `ID_W`/`DATA_W` defaults, shared with `regm`.
  - The `{id,data}` store-word packing function, used by both ends.
  - The FSM state enum.
- No sub-module: FSM, counter and output registers live in one module.

## Test plan
- Write `cmd_id=8'h01`, `cmd_wdata=32'hffff_1111` → `store_data=40'h01_ffff_1111` with `store_data_f` high for exactly one cycle; `store_data=0` before and after.
- Three consecutive writes (ids 1, 2, 3) on consecutive cycles → three consecutive strobe cycles, `cmd_ready` never drops, no `rsp_valid`.
- Read id 8'h01 against a `regm` model with L=2 holding `32'hffff_1111`:
  - `req_id_f` pulse with `req_id=8'h01`.
  - `rsp_valid` 3 cycles after the pulse, `rsp_rdata=32'hffff_1111`, `rsp_err=0`, `rsp_id=8'h01`.
- Read id 8'h07 with the responder silent and TIMEOUT=16 → `rsp_valid` 16 cycles after `req_id_f`, `rsp_err=1`, `rsp_rdata=0`; a stray `req_data_f` afterward is ignored.
- Read completes with `rsp_ready` held low 5 cycles → response fields stable, `cmd_ready=0` throughout; handshake then IDLE, and the next command is accepted the following cycle.
- `sys_rst` low for one cycle during RD_WAIT → all outputs zero, FSM IDLE, no response emitted; a subsequent read completes normally.
